// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares the single SDRAM command engine between the periodic
//   auto-refresh, a write client and a read client. Refresh always wins;
//   a simultaneous write/read pair alternates, starting with the write.
//   The winning request's address/data are latched and one command is issued
//   to the engine. No further arbitration happens until the engine returns
//   cmd_done.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   init_done     engine power-up initialisation complete (level)
//   wr_req        write request, held until wr_ack
//   waddr, wdata  write address/data, valid with wr_req
//   wr_ack        1-cycle pulse: write accepted
//   rd_req        read request, held until rd_ack
//   raddr         read address, valid with rd_req
//   rd_ack        1-cycle pulse: read accepted
//   cmd_valid     1-cycle pulse: new command for the engine
//   cmd_type      2'b00 refresh, 2'b01 write, 2'b10 read
//   cmd_addr      latched address (0 for refresh)
//   cmd_wdata     latched write data (0 for refresh/read)
//   cmd_done      1-cycle pulse from the engine: command finished
//   busy          a command is outstanding at the engine
//   ref_overrun   sticky: a refresh period elapsed with a refresh still pending

module sdram_arbiter #(
  parameter int          ADDR_W         = 22,
  parameter int          DATA_W         = 16,
  parameter int unsigned REFRESH_PERIOD = 780,
  parameter int          CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] raddr,
  output logic              rd_ack,
  output logic              cmd_valid,
  output logic [1:0]        cmd_type,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_done,
  output logic              busy,
  output logic              ref_overrun
);

  localparam logic [2:0] S_WAIT_INIT = 3'd0;
  localparam logic [2:0] S_ARB       = 3'd1;
  localparam logic [2:0] S_REF       = 3'd2;
  localparam logic [2:0] S_WR        = 3'd3;
  localparam logic [2:0] S_RD        = 3'd4;

  localparam logic [1:0] CMD_REFRESH = 2'b00;
  localparam logic [1:0] CMD_WRITE   = 2'b01;
  localparam logic [1:0] CMD_READ    = 2'b10;

  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_PERIOD - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] ref_cnt;
  logic             ref_pend;
  logic             last_was_rd;
  logic             ref_wrap;
  logic             grant_ref;
  logic             grant_wr;
  logic             grant_rd;

  // Wrap strobe and the arbitration decision. Everything freezes while
  // init_done is low, so a dropped init_done parks the FSM and the timer.
  always_comb begin
    ref_wrap  = init_done && (ref_cnt == REF_LAST);
    grant_ref = 1'b0;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    if (state == S_ARB && init_done) begin
      if (ref_pend) begin
        grant_ref = 1'b1;
      end else if (wr_req && rd_req) begin
        // Tie goes to whoever was not served last.
        if (last_was_rd) grant_wr = 1'b1;
        else             grant_rd = 1'b1;
      end else if (wr_req) begin
        grant_wr = 1'b1;
      end else if (rd_req) begin
        grant_rd = 1'b1;
      end
    end
  end

  // Free-running refresh interval timer; keeps counting while commands run.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= '0;
    end else if (init_done) begin
      if (ref_wrap) ref_cnt <= '0;
      else          ref_cnt <= ref_cnt + CNT_W'(1);
    end
  end

  // Pending-refresh flag. A wrap on the grant cycle wins, so that new
  // period's refresh is not lost. A wrap that finds the previous refresh
  // still pending flags an overrun, which only reset clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_pend    <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      if (ref_wrap) begin
        ref_pend <= 1'b1;
        if (ref_pend) ref_overrun <= 1'b1;
      end else if (grant_ref) begin
        ref_pend <= 1'b0;
      end
    end
  end

  // Grant FSM. Leaving a command state always passes through ARB, so there
  // is at least one idle cycle between cmd_done and the next cmd_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_WAIT_INIT;
    end else begin
      case (state)
        S_WAIT_INIT: if (init_done) state <= S_ARB;
        S_ARB: begin
          if (grant_ref)     state <= S_REF;
          else if (grant_wr) state <= S_WR;
          else if (grant_rd) state <= S_RD;
        end
        S_REF, S_WR, S_RD: if (cmd_done && init_done) state <= S_ARB;
        default: state <= S_WAIT_INIT;
      endcase
    end
  end

  // Command outputs are registered on the grant edge. Address/data hold
  // until the next grant. Strobes and acks are single-cycle pulses.
  // last_was_rd starts as "read" so the first tie goes to the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid   <= 1'b0;
      cmd_type    <= CMD_REFRESH;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      wr_ack      <= 1'b0;
      rd_ack      <= 1'b0;
      last_was_rd <= 1'b1;
    end else begin
      cmd_valid <= grant_ref | grant_wr | grant_rd;
      wr_ack    <= grant_wr;
      rd_ack    <= grant_rd;
      if (grant_ref) begin
        cmd_type  <= CMD_REFRESH;
        cmd_addr  <= '0;
        cmd_wdata <= '0;
      end else if (grant_wr) begin
        cmd_type    <= CMD_WRITE;
        cmd_addr    <= waddr;
        cmd_wdata   <= wdata;
        last_was_rd <= 1'b0;
      end else if (grant_rd) begin
        cmd_type    <= CMD_READ;
        cmd_addr    <= raddr;
        cmd_wdata   <= '0;
        last_was_rd <= 1'b1;
      end
    end
  end

  assign busy = (state == S_REF) || (state == S_WR) || (state == S_RD);

endmodule
